// File: rtl/pwm_demod.sv
// pwm_demod: recovers one SAMPLE_W-bit sample per 2**SAMPLE_W-clock PWM frame.
// Define PWM_DEMOD_GLITCH_EN to insert a 3-tap majority filter before edge detection.
module pwm_demod #(
    parameter int SAMPLE_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pwm_in,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    output logic                locked,
    output logic                sync_err
);
    typedef enum logic [1:0] {HUNT, ACQ, LOCKED} state_t;
    localparam logic [SAMPLE_W-1:0] POS_MAX = '1;
    state_t              state_q, state_d;
    logic                s1_q, s2_q, prev_q, pwm_s, edge_det;
    logic [SAMPLE_W-1:0] pos_q, pos_d, sample_q, sample_d;
    logic [SAMPLE_W:0]   hcnt_q, hcnt_d, total;
    logic                valid_q, valid_d, locked_q, locked_d, err_q, err_d;

    // Synchronizer and edge history reset high so a constant-high input never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            s1_q   <= pwm_in;
            s2_q   <= s1_q;
            prev_q <= pwm_s;
        end
    end

`ifdef PWM_DEMOD_GLITCH_EN
    logic h1_q, h2_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1_q <= 1'b1;
            h2_q <= 1'b1;
        end else begin
            h1_q <= s2_q;
            h2_q <= h1_q;
        end
    end
    assign pwm_s = (s2_q & h1_q) | (s2_q & h2_q) | (h1_q & h2_q);
`else
    assign pwm_s = s2_q;
`endif

    assign edge_det = pwm_s & ~prev_q;
    assign total    = hcnt_q + (SAMPLE_W+1)'(pwm_s);

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        hcnt_d   = hcnt_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        locked_d = locked_q;
        if (state_q == HUNT) begin
            if (edge_det) begin
                state_d = ACQ;
                pos_d   = SAMPLE_W'(1);
                hcnt_d  = (SAMPLE_W+1)'(1);
            end
        end else if (edge_det && pos_q != '0) begin
            // Misaligned edge restarts the frame here; the aborted frame is dropped.
            err_d    = 1'b1;
            locked_d = 1'b0;
            state_d  = ACQ;
            pos_d    = SAMPLE_W'(1);
            hcnt_d   = (SAMPLE_W+1)'(1);
        end else if (pos_q == POS_MAX) begin
            sample_d = total[SAMPLE_W] ? '1 : total[SAMPLE_W-1:0];
            valid_d  = 1'b1;
            locked_d = 1'b1;
            state_d  = LOCKED;
            pos_d    = '0;
            hcnt_d   = '0;
        end else begin
            pos_d  = pos_q + SAMPLE_W'(1);
            hcnt_d = total;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            pos_q    <= '0;
            hcnt_q   <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            hcnt_q   <= hcnt_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign locked       = locked_q;
    assign sync_err     = err_q;
endmodule

// File: tb/tb_pwm_demod.sv
// tb_pwm_demod: random PWM streams decoded by a frame-level reference model into a scoreboard.
module tb_pwm_demod;
    localparam int FRAME = 256;
`ifdef PWM_DEMOD_GLITCH_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif
    typedef struct {int kind; int val; int at;} ev_t;

    logic       clk = 1'b0, rst_n = 1'b0, pwm_in = 1'b1;
    logic [7:0] sample;
    logic       sample_valid, locked, sync_err;
    int         pc = 0, checks = 0, errors = 0;
    bit         b[$];
    ev_t        q[$];

    pwm_demod #(.SAMPLE_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .sample(sample),
        .sample_valid(sample_valid), .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pc <= pc + 1;

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at pc=%0d", nm, act, exp, pc);
        end
    endfunction

    // Level seen by the detector for stream bit j (majority of neighbours when filtered).
    function automatic bit fb(input int j);
`ifdef PWM_DEMOD_GLITCH_EN
        bit a = (j > 0) ? b[j-1] : 1'b1;
        bit c = (j + 1 < b.size()) ? b[j+1] : b[b.size()-1];
        return (a & b[j]) | (a & c) | (b[j] & c);
`else
        return b[j];
`endif
    endfunction

    task automatic model(input int n0);
        bit prev = 1'b1, run = 1'b0, f, rise;
        int start = 0, cnt = 0, v;
        for (int j = 0; j <= b.size() - LAT; j++) begin
            f = fb(j);
            rise = f && !prev;
            prev = f;
            if (!run) begin
                if (rise) begin run = 1'b1; start = j; cnt = 0; end
            end else if (rise && j != start) begin
                q.push_back('{1, 0, n0 + j + LAT});
                start = j;
                cnt = 0;
            end
            if (run) begin
                cnt += int'(f);
                if (j - start == FRAME - 1) begin
                    v = (cnt > FRAME - 1) ? FRAME - 1 : cnt;
                    q.push_back('{0, v, n0 + j + LAT});
                    start = j + 1;
                    cnt = 0;
                end
            end
        end
    endtask

    task automatic lows(input int n);
        repeat (n) b.push_back(1'b0);
    endtask

    task automatic highs(input int n);
        repeat (n) b.push_back(1'b1);
    endtask

    task automatic frame(input int v, input int gl = -1);
        for (int i = 0; i < FRAME; i++) b.push_back(i < v || i == gl);
    endtask

    task automatic rst_checks();
        chk("rst_sample", int'(sample), 0);
        chk("rst_valid", int'(sample_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_sync_err", int'(sync_err), 0);
    endtask

    task automatic run_seg();
        @(negedge clk);
        model(pc);
        rst_n = 1'b1;
        foreach (b[k]) begin
            if (k != 0) @(negedge clk);
            pwm_in = b[k];
        end
        @(negedge clk);
        rst_n = 1'b0;
        pwm_in = 1'b1;
        #1;
        rst_checks();
        chk("leftover_events", q.size(), 0);
        q.delete();
        b.delete();
        repeat (3) @(negedge clk);
    endtask

    always @(posedge clk) begin
        ev_t e;
        #1;
        if (sample_valid || sync_err) begin
            if (sample_valid && sync_err) begin
                checks++;
                errors++;
                $display("FAIL both_high valid=1 sync_err=1 required exclusive at pc=%0d", pc);
            end
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event valid=%0d sync_err=%0d sample=%0d at pc=%0d",
                         sample_valid, sync_err, sample, pc);
            end else begin
                e = q.pop_front();
                chk("event_kind", int'(sync_err), e.kind);
                chk("event_time", pc, e.at);
                chk("locked", int'(locked), e.kind ? 0 : 1);
                if (e.kind == 0) chk("sample", int'(sample), e.val);
            end
        end
    end

    initial begin
        int v;
        repeat (3) @(negedge clk);
        rst_checks();
        highs(700);
        run_seg();
        lows($urandom_range(5, 200));
        repeat (5) frame(100);
        run_seg();
        lows(37);
        frame(100); frame(100); frame(0); frame(255); frame(1); frame(128);
        frame(256); frame(256); frame(100);
        run_seg();
        lows(10);
        repeat (3) frame(64);
        lows(37);
        repeat (3) frame(64);
        run_seg();
        lows(20);
        frame(80); frame(80, 200); frame(80, 150); frame(80);
        for (int i = 0; i < 120; i++) b.push_back(i < 80);
        run_seg();
        repeat (6) begin
            lows($urandom_range(1, 300));
            repeat (6) begin
                if ($urandom % 4 == 0) lows($urandom_range(1, 255));
                v = $urandom_range(0, 256);
                frame(v, ($urandom % 3 == 0) ? int'($urandom_range(0, 255)) : -1);
            end
            run_seg();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
